// File: rtl/piso_tx_8_bit.sv
// piso_tx_8_bit: parallel-in/serial-out transmitter, LSB first.
// Frame: start (0), DATA_W data bits, optional even-parity bit, stop (1).
// Optional feature macro: TX_PARITY_EN (inserts the PARITY state and parity bit).
// Handshake: a word is accepted on any rising clk edge where load=1 and
// ready=1; load while busy is dropped. done pulses for one cycle when the
// stop bit has been held for its full period.
module piso_tx_8_bit #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic              load,
    output logic              ready,
    output logic              busy,
    output logic              tx,
    output logic              done,
    output logic [2:0]        state_dbg
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                bit_end;
`ifdef TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    // Last cycle of the current serial bit period.
    assign bit_end = (clk_cnt_q == CNT_LAST);

    // Next-state, counters, shift register and next registered outputs.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
`ifdef TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q != IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (load) begin
                    state_d   = START;
                    shift_d   = data;
                    bit_cnt_d = '0;
                    clk_cnt_d = '0;
                    tx_d      = 1'b0;
`ifdef TX_PARITY_EN
                    parity_d  = ^data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_d[0];
                    end
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // State and output registers; reset aborts any frame and forces the line high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
`ifdef TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
`ifdef TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx        = tx_q;
    assign done      = done_q;
    assign ready     = ready_q;
    assign busy      = ~ready_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_piso_tx_8_bit.sv
// Bench for piso_tx_8_bit: DUT a uses default timing (4 clks/bit), DUT b uses
// 1 clk/bit. Stimulus pushes hand-built frames into per-DUT expected queues;
// a monitor per DUT decodes the serial line and pops/compares each frame.
// Honours TX_PARITY_EN the same way the design does.
module tb_piso_tx_8_bit;

    localparam int DW    = 8;
    localparam int CPB_A = 4;
    localparam int CPB_B = 1;
`ifdef TX_PARITY_EN
    localparam int F      = DW + 3;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int F      = DW + 2;
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic [DW-1:0] data_a, data_b;
    logic          load_a, load_b;
    logic          ready_a, busy_a, tx_a, done_a;
    logic          ready_b, busy_b, tx_b, done_b;
    logic [2:0]    state_a, state_b;

    logic [F-1:0]  exp_qa[$];
    logic [F-1:0]  exp_qb[$];
    int            n_cmp;
    int            n_err;

    piso_tx_8_bit #(.DATA_W(DW), .CLKS_PER_BIT(CPB_A)) u_dut_a (
        .clk(clk), .reset(reset), .data(data_a), .load(load_a),
        .ready(ready_a), .busy(busy_a), .tx(tx_a), .done(done_a),
        .state_dbg(state_a)
    );

    piso_tx_8_bit #(.DATA_W(DW), .CLKS_PER_BIT(CPB_B)) u_dut_b (
        .clk(clk), .reset(reset), .data(data_b), .load(load_b),
        .ready(ready_b), .busy(busy_b), .tx(tx_b), .done(done_b),
        .state_dbg(state_b)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (errors so far %0d)", n_err);
        $fatal(1, "watchdog");
    end

    function automatic logic get_tx(input int id);
        return (id == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic get_ready(input int id);
        return (id == 0) ? ready_a : ready_b;
    endfunction

    function automatic logic get_done(input int id);
        return (id == 0) ? done_a : done_b;
    endfunction

    function automatic string pfx(input int id);
        return (id == 0) ? "a_" : "b_";
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame bit 0 is the start bit; par is the hand-computed even parity of d.
    task automatic push(input int id, input logic [DW-1:0] d, input logic par);
        logic [DW+2:0] full;
        logic [F-1:0]  fr;
        full = {1'b1, par, d, 1'b0};
        fr   = F'(PAR_EN ? full : {1'b0, 1'b1, d, 1'b0});
        if (id == 0) exp_qa.push_back(fr);
        else         exp_qb.push_back(fr);
    endtask

    // Present one word; optionally record it as an expected frame.
    task automatic send(input int id, input logic [DW-1:0] d, input logic par, input bit expect_it);
        int w;
        w = 0;
        @(negedge clk);
        while (get_ready(id) !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check({pfx(id), "ready_before_load"}, get_ready(id), 1);
        if (id == 0) begin load_a = 1'b1; data_a = d; end
        else         begin load_b = 1'b1; data_b = d; end
        if (expect_it) push(id, d, par);
        @(posedge clk);
        #1;
        if (id == 0) load_a = 1'b0;
        else         load_b = 1'b0;
    endtask

    // Returns at the negedge where done is seen (bounded).
    task automatic wait_done(input int id);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (get_done(id) !== 1'b1 && w < 200);
        check({pfx(id), "done_seen"}, get_done(id), 1);
    endtask

    // Monitor: decode a frame from the first low sample, then compare.
    task automatic monitor(input int id);
        int           c;
        logic [F-1:0] obs;
        logic [F-1:0] exp;
        bit           aborted, rdy_bad, done_bad;
        int           qsz;
        c = (id == 0) ? CPB_A : CPB_B;
        forever begin
            @(negedge clk);
            if (reset == 1'b0 && get_tx(id) == 1'b0) begin
                obs = '0;
                aborted = 1'b0;
                rdy_bad = 1'b0;
                done_bad = 1'b0;
                for (int n = 0; n < F * c; n++) begin
                    if (n > 0) @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (n % c == c / 2) obs[n / c] = get_tx(id);
                    if (get_ready(id) !== 1'b0) rdy_bad = 1'b1;
                    if (get_done(id) !== 1'b0) done_bad = 1'b1;
                end
                if (!aborted) begin
                    @(negedge clk);
                    if (reset) aborted = 1'b1;
                end
                if (!aborted) begin
                    check({pfx(id), "ready_low_in_frame"}, {31'd0, rdy_bad}, 0);
                    check({pfx(id), "no_early_done"}, {31'd0, done_bad}, 0);
                    check({pfx(id), "done_at_frame_end"}, get_done(id), 1);
                    check({pfx(id), "ready_at_frame_end"}, get_ready(id), 1);
                    check({pfx(id), "idle_tx_at_frame_end"}, get_tx(id), 1);
                    qsz = (id == 0) ? exp_qa.size() : exp_qb.size();
                    check({pfx(id), "frame_was_expected"}, {31'd0, qsz > 0}, 1);
                    if (qsz > 0) begin
                        exp = (id == 0) ? exp_qa.pop_front() : exp_qb.pop_front();
                        check({pfx(id), "frame_bits"}, obs, exp);
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    // Directed stimulus
    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b1;
        load_a = 1'b0;
        load_b = 1'b0;
        data_a = '0;
        data_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("a_reset_tx", tx_a, 1);
        check("a_reset_ready", ready_a, 1);
        check("a_reset_busy", busy_a, 0);
        check("a_reset_done", done_a, 0);
        check("b_reset_tx", tx_b, 1);
        check("b_reset_ready", ready_b, 1);
        @(negedge clk);
        #1 reset = 1'b0;

        // Single frame 0xA5 -> 0,1,0,1,0,0,1,0,1,1
        send(0, 8'hA5, 1'b0, 1'b1);
        check("a_busy_after_accept", busy_a, 1);
        check("a_tx_low_after_accept", tx_a, 0);
        wait_done(0);

        // Back-to-back 0x00 then 0xFF with load held high
        @(negedge clk);
        load_a = 1'b1;
        data_a = 8'h00;
        push(0, 8'h00, 1'b0);
        push(0, 8'hFF, 1'b0);
        @(posedge clk);
        #1 data_a = 8'hFF;
        wait_done(0);
        check("b2b_idle_tx", tx_a, 1);
        check("b2b_idle_ready", ready_a, 1);
        @(negedge clk);
        check("b2b_start_tx", tx_a, 0);
        check("b2b_start_busy", busy_a, 1);
        load_a = 1'b0;
        wait_done(0);

        // Load while busy is dropped
        send(0, 8'h3C, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        load_a = 1'b1;
        data_a = 8'h81;
        @(posedge clk);
        #1;
        load_a = 1'b0;
        data_a = 8'h00;
        wait_done(0);
        repeat (60) @(negedge clk);
        check("a_no_queued_frame_tx", tx_a, 1);

        // Reset during data bit 3 of 0x0F, then a clean 0x55 frame
        send(0, 8'h0F, 1'b0, 1'b0);
        repeat (17) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_tx", tx_a, 1);
        check("abort_ready", ready_a, 1);
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        send(0, 8'h55, 1'b0, 1'b1);
        wait_done(0);

`ifdef TX_PARITY_EN
        // Parity bit values and 44-cycle frame length (checked by the monitor)
        send(0, 8'h07, 1'b1, 1'b1);
        wait_done(0);
        send(0, 8'h03, 1'b0, 1'b1);
        wait_done(0);
`endif

        // One clock per bit: 0xC3 -> 0,1,1,0,0,0,0,1,1,1
        send(1, 8'hC3, 1'b0, 1'b1);
        wait_done(1);

        repeat (5) @(negedge clk);
        check("a_queue_drained", exp_qa.size(), 0);
        check("b_queue_drained", exp_qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
